// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard used by decode for RAW/WAW hazard detection.
module regfile_mp #(
    parameter  int XLEN    = 32,
    parameter  int NREG    = 32,
    parameter  int NRD     = 2,
    parameter  int NWR     = 2,
    parameter  int BYPASS  = 1,
    parameter  int ZERO_R0 = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NWR-1:0]       we_i,
    input  logic [NWR*AW-1:0]    waddr_i,
    input  logic [NWR*XLEN-1:0]  wdata_i,
    input  logic [NRD*AW-1:0]    raddr_i,
    output logic [NRD*XLEN-1:0]  rdata_o,
    output logic [NRD-1:0]       rbusy_o,
    input  logic                 issue_vld_i,
    input  logic [AW-1:0]        issue_rd_i,
    output logic                 issue_ok_o
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] wr_hit;

    // wr_hit[r]: some enabled write port lands on r this cycle (r0 excluded when hardwired).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_hit = '0;
        for (int k = 0; k < NWR; k++) begin
            for (int r = 0; r < NREG; r++) begin
                if (we_i[k] && waddr_i[k*AW +: AW] == AW'(r)) begin
                    wr_hit[r] = 1'b1;
                end
            end
        end
        if (ZERO_R0 != 0) begin
            wr_hit[0] = 1'b0;
        end
    end

    // Ports are visited in ascending order, so the highest-index enabled port wins a collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the array is reset explicitly because every register must read 0 after reset,
            // which also ties it to flops rather than a RAM macro.
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we_i[k] && !(ZERO_R0 != 0 && waddr_i[k*AW +: AW] == '0)) begin
                    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
                    regs[waddr_i[k*AW +: AW]] <= wdata_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int j = 0; j < NRD; j++) begin
            rdata_o[j*XLEN +: XLEN] = regs[raddr_i[j*AW +: AW]];
            if (BYPASS != 0 && wr_hit[raddr_i[j*AW +: AW]]) begin
                for (int k = 0; k < NWR; k++) begin
                    if (we_i[k] && waddr_i[k*AW +: AW] == raddr_i[j*AW +: AW]) begin
                        rdata_o[j*XLEN +: XLEN] = wdata_i[k*XLEN +: XLEN];
                    end
                end
            end
            rbusy_o[j] = busy[raddr_i[j*AW +: AW]]
                       & ~((BYPASS != 0) & wr_hit[raddr_i[j*AW +: AW]]);
        end
        if (!rst_ni) begin
            rdata_o = '0;
            rbusy_o = '0;
        end
    end

    // A producer retiring this cycle frees its destination for a new issue immediately.
    assign issue_ok_o = rst_ni & (~busy[issue_rd_i] | wr_hit[issue_rd_i]);

    // Set after clear: a same-cycle retire and re-issue leaves the register pending.
    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (issue_vld_i && issue_ok_o) begin
            busy_nxt[issue_rd_i] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RV32I core.
- Replaces the fixed 2R/1W file with NRD combinational read ports and NWR synchronous write ports.
- Adds optional write-to-read bypass and a per-register scoreboard (busy bits) used by decode for RAW/WAW hazard detection.
- Sits between decode (read, issue) and writeback (write, busy clear).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of 2, >= 2.
- NRD, 2, number of read ports, >= 1.
- NWR, 2, number of write ports, >= 1.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value only.
- ZERO_R0, 1, 1 = register 0 hardwired to zero; writes and issues to it are ignored.
- AW (localparam), $clog2(NREG), register address width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- we_i  in  NWR  per-port write enable.
- waddr_i  in  NWR*AW  write addresses; port k at [k*AW +: AW].
- wdata_i  in  NWR*XLEN  write data; port k at [k*XLEN +: XLEN].
- raddr_i  in  NRD*AW  read addresses, packed as above.
- rdata_o  out  NRD*XLEN  read data, packed as above.
- rbusy_o  out  NRD  per read port: addressed register has an outstanding producer.
- issue_vld_i  in  1  decode requests to mark issue_rd_i busy.
- issue_rd_i  in  AW  destination register of the issuing instruction.
- issue_ok_o  out  1  issue accepted this cycle (no WAW hazard).

Behaviour:
- Reset: asynchronous clear on rst_ni low; all registers and all busy bits go to 0 immediately.
  - While rst_ni is low: rdata_o = 0, rbusy_o = 0, issue_ok_o = 0.
  - A reset mid-operation discards any write or issue in that cycle.
- Write: on clk_i rising edge, every port with we_i[k]=1 writes wdata_k to reg[waddr_k].
  - Same-address collision: the highest-index enabled port wins.
  - ZERO_R0=1: writes to address 0 are dropped, and reg 0 always reads 0.
- Read: purely combinational, zero latency.
  - BYPASS=1: if any enabled write port targets raddr_j (and the address is not r0 under ZERO_R0), rdata_j = the highest-index matching wdata. Otherwise rdata_j = the stored value.
  - BYPASS=0: rdata_j always equals the stored value; new data is visible the cycle after the write.
- Scoreboard: one busy bit per register; busy[0] is constant 0 when ZERO_R0=1.
  - issue_ok_o = ~busy[issue_rd_i] OR (some enabled write port targets issue_rd_i this cycle).
  - On the edge, busy[r] is cleared if any enabled write port targets r.
  - busy[r] is set if issue_vld_i & issue_ok_o & issue_rd_i == r.
  - Set wins over clear on the same register in the same cycle: the old producer retires and the new one is pending.
  - issue_vld_i with issue_ok_o=0: no state change; decode must hold the request.
  - Issue to r0 under ZERO_R0: issue_ok_o=1, no bit is set.
- rbusy_j:
  - BYPASS=1: busy[raddr_j] AND NOT (a same-cycle write to raddr_j).
  - BYPASS=0: busy[raddr_j] as stored.
- Writes with no prior issue are legal and simply clear an already-0 busy bit.
- No X propagation: unused default branches drive 0.

Test Plan:
- Reset and r0: after reset, read r1..r31 on all ports -> 0. Write 0xDEADBEEF to r0 -> reads 0. Assert rst_ni low mid-run after writing r5=0x5 -> r5 reads 0 immediately and busy cleared.
- Write/read basic (BYPASS=0): write r3=0x12345678 on port0 at cycle n -> rdata of r3 = old value in cycle n, 0x12345678 in cycle n+1.
- Bypass and collision (BYPASS=1): port0 writes r7=0x11 and port1 writes r7=0x22 in the same cycle, with raddr0=r7 -> rdata0=0x22 that cycle; stored r7=0x22 next cycle.
- Scoreboard RAW: issue r9 -> next cycle rbusy for raddr=r9 is 1. Write r9=0xA5 -> that cycle rbusy=0 (BYPASS=1) and rdata=0xA5. Next cycle busy[9]=0.
- WAW stall and set-over-clear: issue r4, then issue r4 again -> issue_ok_o=0. In the same cycle as the write to r4, issue r4 -> issue_ok_o=1 and busy[4] remains 1 afterwards.
- Parameter sweep: XLEN=64, NREG=16, NRD=3, NWR=1, ZERO_R0=0 -> r0 writable (write 0x1 and read it back). Random write/issue traffic is checked against a reference model for 10k cycles.
